// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter sizes, state encoding and grant index/one-hot helpers
package arb_pkg;
  localparam int ARB_N = 8;
  localparam int ARB_IDXW = 3;
  typedef enum logic {IDLE, GRANT} state_e;
  function automatic logic [ARB_IDXW-1:0] onehot_to_idx(input logic [ARB_N-1:0] oh);
    onehot_to_idx = '0;
    for (int i = 0; i < ARB_N; i++) onehot_to_idx |= oh[i] ? ARB_IDXW'(i) : '0;
  endfunction
  function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [ARB_IDXW-1:0] idx);
    return ARB_N'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker, first requester at or after base wins
module rr_pick import arb_pkg::*; #(
  parameter int N = ARB_N,
  localparam int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] base,
  output logic            any,
  output logic [IDXW-1:0] winner
);
  logic [N-1:0] rot;
  logic [IDXW-1:0] off;
  assign any = |req;
  assign winner = off + base;
  // rotate so base sits at bit 0, then the lowest set bit is the offset from base
  always_comb begin
    off = '0;
    for (int i = 0; i < N; i++) rot[i] = req[IDXW'(i) + base];
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? IDXW'(i) : off;
  end
endmodule

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter with registered one-hot grant and valid/ready; RR_ARB_LOCK_EN adds burst lock
module rr_arbiter_8 import arb_pkg::*; #(
  parameter int N = ARB_N,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  input  logic            gnt_ready,
  output logic [IDXW-1:0] gnt_idx
`ifdef RR_ARB_LOCK_EN
  ,
  input  logic            lock
`endif
);
  state_e st, st_nx;
  logic [N-1:0] gnt_nx;
  logic [IDXW-1:0] ptr, ptr_nx, idx_nx, base, win;
  logic hs, ld, lk, any;
  assign gnt_valid = st == GRANT;
  assign hs = gnt_valid & gnt_ready;
  assign ld = !gnt_valid | hs;
`ifdef RR_ARB_LOCK_EN
  assign lk = hs & lock;
`else
  assign lk = 1'b0;
`endif
  assign base = hs ? (lk ? gnt_idx : gnt_idx + 1'b1) : ptr;
  rr_pick #(.N(N)) u_pick (
    .req(req),
    .base(base),
    .any(any),
    .winner(win)
  );
  // next grant is loaded only when idle or on handshake; a stalled grant stays frozen
  always_comb begin
    st_nx = st;
    gnt_nx = gnt;
    idx_nx = gnt_idx;
    ptr_nx = ptr;
    if (ld) begin
      st_nx = any ? GRANT : IDLE;
      gnt_nx = any ? N'(1) << win : '0;
      idx_nx = any ? win : '0;
    end
    if (hs & !lk) ptr_nx = gnt_idx + 1'b1;
  end
  // grant registers and priority pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      gnt <= '0;
      gnt_idx <= '0;
      ptr <= '0;
    end else begin
      st <= st_nx;
      gnt <= gnt_nx;
      gnt_idx <= idx_nx;
      ptr <= ptr_nx;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed and random self-checking bench for rr_arbiter_8 (lock test with RR_ARB_LOCK_EN)
module tb_rr_arbiter_8;
  import arb_pkg::*;
  logic clk, rst_n, gnt_valid, gnt_ready;
  logic [7:0] req, gnt;
  logic [2:0] gnt_idx;
`ifdef RR_ARB_LOCK_EN
  logic lock;
`endif
  int n_cmp, n_err;
  logic stl;
  logic [7:0] pg;
  logic m_v, mhs, found;
  logic [7:0] m_gnt;
  logic [2:0] m_idx, m_ptr, mb;
  int wt[8];
  int maxw;

  rr_arbiter_8 dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .gnt(gnt),
    .gnt_valid(gnt_valid),
    .gnt_ready(gnt_ready),
    .gnt_idx(gnt_idx)
`ifdef RR_ARB_LOCK_EN
    ,
    .lock(lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) stl = 1'b0;
    else begin
      chk("inv_onehot", gnt_valid ? 32'($onehot(gnt)) : 32'(gnt == 8'h00), 1);
      chk("inv_idx", gnt, gnt_valid ? idx_to_onehot(gnt_idx) : 8'h00);
      if (stl) chk("inv_hold", gnt, pg);
      stl = gnt_valid & !gnt_ready;
      pg = gnt;
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    stl = 1'b0;
    pg = '0;
`ifdef RR_ARB_LOCK_EN
    lock = 1'b0;
`endif
    // T1 reset then full-load rotation
    rst_n = 1'b1;
    req = 8'hFF;
    gnt_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("t1_rst_gnt", gnt, 8'h00);
    chk("t1_rst_valid", gnt_valid, 0);
    chk("t1_rst_idx", gnt_idx, 0);
    tick;
    tick;
    chk("t1_hold_rst", gnt, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick;
      chk("t1_gnt", gnt, 32'(1) << (i % 8));
      chk("t1_valid", gnt_valid, 1);
    end
    // T2 single requester, back to idle first
    req = 8'h00;
    tick;
    chk("t2_idle", gnt_valid, 0);
    chk("t2_idle_gnt", gnt, 8'h00);
    req = 8'h20;
    tick;
    chk("t2_gnt", gnt, 8'h20);
    chk("t2_idx", gnt_idx, 5);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t2_regnt", gnt, 8'h20);
    end
    // T3 stall with toggling requests
    req = 8'h00;
    tick;
    chk("t3_idle", gnt_valid, 0);
    req = 8'h04;
    gnt_ready = 1'b0;
    tick;
    chk("t3_gnt", gnt, 8'h04);
    for (int i = 0; i < 5; i++) begin
      req = (i % 2 == 0) ? 8'hF0 : 8'h0B;
      tick;
      chk("t3_stall_gnt", gnt, 8'h04);
      chk("t3_stall_idx", gnt_idx, 2);
    end
    gnt_ready = 1'b1;
    req = 8'h83;
    tick;
    chk("t3_next", gnt, 8'h80);
    tick;
    chk("t3_wrap", gnt, 8'h01);
    // T5 asynchronous reset mid-grant
    gnt_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", gnt, 8'h00);
    chk("t5_async_valid", gnt_valid, 0);
    chk("t5_async_idx", gnt_idx, 0);
    req = 8'h40;
    gnt_ready = 1'b1;
    tick;
    rst_n = 1'b1;
    tick;
    chk("t5_gnt", gnt, 8'h40);
    chk("t5_idx", gnt_idx, 6);
    // T4 random traffic against a reference model and fairness scoreboard
    rst_n = 1'b0;
    req = 8'h00;
    #1;
    chk("t4_rst_valid", gnt_valid, 0);
    m_v = 1'b0;
    m_gnt = '0;
    m_idx = '0;
    m_ptr = '0;
    maxw = 0;
    for (int j = 0; j < 8; j++) wt[j] = 0;
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
      gnt_ready = $urandom_range(0, 9) < 7;
      mhs = m_v & gnt_ready;
      for (int j = 0; j < 8; j++) begin
        if (!req[j] || (m_v && m_gnt[j])) wt[j] = 0;
        else if (mhs) wt[j]++;
        if (wt[j] > maxw) maxw = wt[j];
      end
      if (!m_v || mhs) begin
        mb = mhs ? m_idx + 3'd1 : m_ptr;
        if (mhs) m_ptr = m_idx + 3'd1;
        found = 1'b0;
        m_gnt = '0;
        m_idx = '0;
        for (int k = 0; k < 8; k++) begin
          if (!found && req[(int'(mb) + k) % 8]) begin
            found = 1'b1;
            m_idx = 3'((int'(mb) + k) % 8);
            m_gnt = 8'(1) << m_idx;
          end
        end
        m_v = found;
      end
      tick;
      chk("t4_valid", gnt_valid, m_v);
      chk("t4_gnt", gnt, m_gnt);
      chk("t4_idx", gnt_idx, m_idx);
    end
    chk("t4_fair", maxw <= 8, 1);
`ifdef RR_ARB_LOCK_EN
    // T6 burst lock holds the same requester
    rst_n = 1'b0;
    req = 8'h09;
    gnt_ready = 1'b1;
    lock = 1'b1;
    tick;
    rst_n = 1'b1;
    tick;
    chk("t6_first", gnt, 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t6_locked", gnt, 8'h01);
    end
    lock = 1'b0;
    tick;
    chk("t6_release", gnt, 8'h08);
    chk("t6_idx", gnt_idx, 3);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
